// File: rtl/cc_cfg_pkg.sv
// Core-complex configuration: the external-memory window and the responder FSM state type.
package cc_cfg_pkg;

  localparam logic [31:0] EXT_MEM_BASE  = 32'h0000_1000;
  localparam logic [31:0] EXT_MEM_END   = 32'h0002_0FFF;
  localparam int unsigned EXT_MEM_WORDS = (EXT_MEM_END - EXT_MEM_BASE + 1) / 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } ext_mem_state_e;

endpackage

// File: rtl/ext_mem_resp_sram.sv
// Single-port word array: byte-enabled synchronous write, asynchronous read.
module ext_mem_resp_sram #(
  parameter int unsigned Depth = 32768,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ext_mem_resp.sv
// External-memory responder with programmable wait states.
// Define EXT_MEM_RESP_ERR_EN to report out-of-range accesses on err_o.
module ext_mem_resp
  import cc_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = EXT_MEM_BASE,
  parameter logic [31:0] END_ADDR    = EXT_MEM_END,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned Words = (END_ADDR - BASE_ADDR + 1) / 4;
  localparam int unsigned Aw    = $clog2(Words);

`ifdef EXT_MEM_RESP_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  ext_mem_state_e state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  logic           accept;
  logic           in_range;
  logic [31:0]    offset;
  logic [Aw-1:0]  word_idx;
  logic [31:0]    mem_rdata;
  logic           unused_offset;

  assign in_range      = (addr_i >= BASE_ADDR) && (addr_i <= END_ADDR);
  assign offset        = addr_i - BASE_ADDR;
  assign word_idx      = offset[Aw+1:2];
  assign unused_offset = ^{offset[31:Aw+2], offset[1:0]};

  assign gnt_o    = !rst_i && ((state_q == StIdle) || (state_q == StResp));
  assign accept   = req_i && gnt_o;
  assign rvalid_o = (state_q == StResp);
  assign rdata_o  = rdata_q;

  // Out-of-range writes never reach the array, whether or not errors are reported.
  ext_mem_resp_sram #(
    .Depth(Words),
    .Aw   (Aw)
  ) u_sram (
    .clk_i  (clk_i),
    .we_i   (accept && we_i && in_range),
    .addr_i (word_idx),
    .be_i   (be_i),
    .wdata_i(wdata_i),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = StResp;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      rdata_d = (!we_i && in_range) ? mem_rdata : 32'h0;
      err_d   = ErrEn && !in_range;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef EXT_MEM_RESP_ERR_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
